// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_axi_pkg
// Description : Shared AXI read-side constants and helpers for the cache read
//               arbiter: requester IDs, cache rd_type encodings, the AR field
//               bundle and rd_type -> arlen/arsize translation.
// Contents    : ID_ICACHE, ID_DCACHE      fixed AXI IDs per requester
//               RD_TYPE_*                 cache request size encodings
//               ar_fields_t               registered AR channel payload
//               rd_type_to_arlen/arsize   AXI burst shape from rd_type
// Revision    : 1.0  initial release
// ============================================================================
package cpu_axi_pkg;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_fields_t;

    // A line refill is four 32-bit beats; everything else is a single beat.
    function automatic logic [7:0] rd_type_to_arlen(input logic [2:0] rd_type);
        return (rd_type == RD_TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    // Line beats are full words; sub-word types encode their size directly
    // in the low two bits.
    function automatic logic [2:0] rd_type_to_arsize(input logic [2:0] rd_type);
        return (rd_type == RD_TYPE_LINE) ? 3'd2 : {1'b0, rd_type[1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_port_tracker.sv
`default_nettype none
// ============================================================================
// Module      : rd_port_tracker
// Description : Per-requester outstanding-read tracker. IDLE -> WAIT_R on
//               accept, back to IDLE on the last beat carrying this port's ID.
//               Routes matching R beats to the requester with zero latency.
// Ports       : clk, reset          clock, synchronous active-high reset
//               i_accept            request accepted this cycle
//               i_beat_en           an R beat is being taken (rvalid & rready)
//               i_rid/i_rlast/i_rdata  R channel beat
//               o_busy              port has a read in flight (WAIT_R)
//               o_ret_valid/o_ret_last/o_ret_data  routed return beat
// Revision    : 1.0  initial release
// ============================================================================
module rd_port_tracker #(
    parameter logic [3:0] PORT_ID = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic        i_beat_en,
    input  logic [3:0]  i_rid,
    input  logic        i_rlast,
    input  logic [31:0] i_rdata,
    output logic        o_busy,
    output logic        o_ret_valid,
    output logic        o_ret_last,
    output logic [31:0] o_ret_data
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_wait_r = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_hit;

    // Only a port that is actually waiting may claim a beat with its ID.
    assign w_hit = (r_state == c_st_wait_r) & i_beat_en & (i_rid == PORT_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_accept) begin
                    w_state_nxt = c_st_wait_r;
                end
            end
            c_st_wait_r: begin
                if (w_hit && i_rlast) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        o_busy      = (r_state == c_st_wait_r);
        o_ret_valid = 1'b0;
        o_ret_last  = 1'b0;
        o_ret_data  = 32'd0;
        if (w_hit) begin
            o_ret_valid = 1'b1;
            o_ret_last  = i_rlast;
            o_ret_data  = i_rdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI AR/R channel pair between the icache refill
//               port (ID 0) and the dcache/uncached port (ID 1). Fixed dcache
//               priority with an icache anti-starvation counter, one read in
//               flight per requester, read-after-write blocking against the
//               write buffer, and a sticky protocol error for stray beats.
// Ports       : clk, reset                    clock, sync active-high reset
//               i_rd_* / i_ret_*              icache request / return
//               d_rd_* / d_ret_*              dcache request / return
//               wr_pending, wr_pend_addr      write buffer hazard inputs
//               ar*                           AXI read-address channel
//               rid, rdata, rlast, rvalid, rready  AXI read-data channel
//               protocol_err                  sticky unexpected-beat flag
// Revision    : 1.0  initial release
// ============================================================================
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_OFF_W   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    input  logic        wr_pending,
    input  logic [31:0] wr_pend_addr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        protocol_err
);

    localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);
    localparam logic [31:0]        c_line_mask  = ~((32'd1 << LINE_OFF_W) - 32'd1);

    localparam logic [0:0] c_ar_idle = 1'b0;
    localparam logic [0:0] c_ar_send = 1'b1;

    logic [0:0]         r_ar_state;
    logic [0:0]         w_ar_state_nxt;
    ar_fields_t         r_ar;
    ar_fields_t         w_ar_load;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               r_protocol_err;

    logic               w_beat_en;
    logic               w_i_busy;
    logic               w_d_busy;
    logic               w_i_raw;
    logic               w_d_raw;
    logic               w_i_elig;
    logic               w_d_elig;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_ar_idle;
    logic               w_accept_i;
    logic               w_accept_d;
    logic               w_accept;
    logic [2:0]         w_sel_type;
    logic [31:0]        w_sel_addr;
    logic               w_unused_ok;

    // --------------------------------------------------------------------
    // Return path: R is always drained outside reset. Gating the beat
    // enable with rready also keeps beats that arrive during reset from
    // reaching either port or the error flag.
    // --------------------------------------------------------------------
    assign rready    = ~reset;
    assign w_beat_en = rvalid & rready;

    rd_port_tracker #(
        .PORT_ID     (ID_ICACHE)
    ) u_i_port (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept_i),
        .i_beat_en   (w_beat_en),
        .i_rid       (rid),
        .i_rlast     (rlast),
        .i_rdata     (rdata),
        .o_busy      (w_i_busy),
        .o_ret_valid (i_ret_valid),
        .o_ret_last  (i_ret_last),
        .o_ret_data  (i_ret_data)
    );

    rd_port_tracker #(
        .PORT_ID     (ID_DCACHE)
    ) u_d_port (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept_d),
        .i_beat_en   (w_beat_en),
        .i_rid       (rid),
        .i_rlast     (rlast),
        .i_rdata     (rdata),
        .o_busy      (w_d_busy),
        .o_ret_valid (d_ret_valid),
        .o_ret_last  (d_ret_last),
        .o_ret_data  (d_ret_data)
    );

    // --------------------------------------------------------------------
    // Eligibility and grant. The RAW compare is line-granular: any pending
    // write to the same line blocks the read until the write drains.
    // --------------------------------------------------------------------
    assign w_i_raw = wr_pending &
                     (wr_pend_addr[31:LINE_OFF_W] == i_rd_addr[31:LINE_OFF_W]);
    assign w_d_raw = wr_pending &
                     (wr_pend_addr[31:LINE_OFF_W] == d_rd_addr[31:LINE_OFF_W]);

    // Offset bits of the pending write address play no part in the hazard.
    assign w_unused_ok = ^wr_pend_addr[LINE_OFF_W-1:0];

    assign w_i_elig  = i_rd_req & ~w_i_busy & ~w_i_raw;
    assign w_d_elig  = d_rd_req & ~w_d_busy & ~w_d_raw;
    assign w_ar_idle = (r_ar_state == c_ar_idle);

    // dcache normally wins a tie; once the icache has been passed over
    // STARVE_LIMIT times in a row it takes the next contested slot.
    assign w_grant_i = w_i_elig & (~w_d_elig | (r_starve_cnt == c_starve_max));
    assign w_grant_d = w_d_elig & ~w_grant_i;

    assign i_rd_rdy   = w_i_elig & w_ar_idle & w_grant_i;
    assign d_rd_rdy   = w_d_elig & w_ar_idle & w_grant_d;
    assign w_accept_i = i_rd_rdy;
    assign w_accept_d = d_rd_rdy;
    assign w_accept   = w_accept_i | w_accept_d;

    // --------------------------------------------------------------------
    // AR payload for the granted requester.
    // --------------------------------------------------------------------
    assign w_sel_type = w_grant_i ? i_rd_type : d_rd_type;
    assign w_sel_addr = w_grant_i ? i_rd_addr : d_rd_addr;

    always_comb begin
        w_ar_load       = '0;
        w_ar_load.id    = w_grant_i ? ID_ICACHE : ID_DCACHE;
        w_ar_load.addr  = (w_sel_type == RD_TYPE_LINE) ? (w_sel_addr & c_line_mask)
                                                       : w_sel_addr;
        w_ar_load.len   = rd_type_to_arlen(w_sel_type);
        w_ar_load.size  = rd_type_to_arsize(w_sel_type);
        w_ar_load.burst = AXI_BURST_INCR;
    end

    // Fields are captured at accept and held until the next accept, so they
    // stay stable for the whole time arvalid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar <= '0;
        end else if (w_accept) begin
            r_ar <= w_ar_load;
        end
    end

    // --------------------------------------------------------------------
    // AR FSM
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_state <= c_ar_idle;
        end else begin
            r_ar_state <= w_ar_state_nxt;
        end
    end

    always_comb begin
        w_ar_state_nxt = r_ar_state;
        case (r_ar_state)
            c_ar_idle: begin
                if (w_accept) begin
                    w_ar_state_nxt = c_ar_send;
                end
            end
            c_ar_send: begin
                if (arready) begin
                    w_ar_state_nxt = c_ar_idle;
                end
            end
            default: w_ar_state_nxt = c_ar_idle;
        endcase
    end

    always_comb begin
        arvalid = (r_ar_state == c_ar_send);
        arid    = r_ar.id;
        araddr  = r_ar.addr;
        arlen   = r_ar.len;
        arsize  = r_ar.size;
        arburst = r_ar.burst;
        arlock  = 2'b00;
        arcache = 4'b0000;
        arprot  = 3'b000;
    end

    // --------------------------------------------------------------------
    // Starvation counter: counts dcache grants taken while the icache was
    // asking; saturates at the limit and clears when the icache is served.
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_accept_i) begin
            r_starve_cnt <= '0;
        end else if (w_accept_d && i_rd_req && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // --------------------------------------------------------------------
    // Sticky protocol error: a taken beat that no waiting port claimed.
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_protocol_err <= 1'b0;
        end else if (w_beat_en && !i_ret_valid && !d_ret_valid) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Self-checking bench for axi_rd_arbiter: a table of grant /
//               eligibility vectors plus directed multi-cycle sequences for
//               line refill, tie-break, starvation, RAW blocking, interleaved
//               returns, stray beats and reset mid-burst.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_rd_req = 1'b0;
    logic [2:0]  i_rd_type = 3'b010;
    logic [31:0] i_rd_addr = 32'd0;
    logic        i_rd_rdy;
    logic        i_ret_valid;
    logic        i_ret_last;
    logic [31:0] i_ret_data;
    logic        d_rd_req = 1'b0;
    logic [2:0]  d_rd_type = 3'b010;
    logic [31:0] d_rd_addr = 32'd0;
    logic        d_rd_rdy;
    logic        d_ret_valid;
    logic        d_ret_last;
    logic [31:0] d_ret_data;
    logic        wr_pending = 1'b0;
    logic [31:0] wr_pend_addr = 32'd0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    axi_rd_arbiter #(
        .STARVE_LIMIT (4),
        .LINE_OFF_W   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rd_req     (i_rd_req),
        .i_rd_type    (i_rd_type),
        .i_rd_addr    (i_rd_addr),
        .i_rd_rdy     (i_rd_rdy),
        .i_ret_valid  (i_ret_valid),
        .i_ret_last   (i_ret_last),
        .i_ret_data   (i_ret_data),
        .d_rd_req     (d_rd_req),
        .d_rd_type    (d_rd_type),
        .d_rd_addr    (d_rd_addr),
        .d_rd_rdy     (d_rd_rdy),
        .d_ret_valid  (d_ret_valid),
        .d_ret_last   (d_ret_last),
        .d_ret_data   (d_ret_data),
        .wr_pending   (wr_pending),
        .wr_pend_addr (wr_pend_addr),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arlock       (arlock),
        .arcache      (arcache),
        .arprot       (arprot),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        wr_p;
        logic [31:0] wr_a;
        logic        exp_i;
        logic        exp_d;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arvalid is high in the current cycle; complete the handshake.
    task automatic ar_accept();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        check("arvalid_after_arready", {31'd0, arvalid}, 32'd0);
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                        input logic exp_i, input logic exp_d);
        tick();
        rvalid = 1'b1;
        rid    = id;
        rdata  = data;
        rlast  = last;
        #1;
        check("i_ret_valid", {31'd0, i_ret_valid}, {31'd0, exp_i});
        check("d_ret_valid", {31'd0, d_ret_valid}, {31'd0, exp_d});
        if (exp_i) begin
            check("i_ret_data", i_ret_data, data);
            check("i_ret_last", {31'd0, i_ret_last}, {31'd0, last});
        end
        if (exp_d) begin
            check("d_ret_data", d_ret_data, data);
            check("d_ret_last", {31'd0, d_ret_last}, {31'd0, last});
        end
    endtask

    task automatic end_beats();
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_perr", {31'd0, protocol_err}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_rready", {31'd0, rready}, 32'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_arid", {28'd0, arid}, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arlen", {24'd0, arlen}, 32'd0);
        check("rst_arburst", {30'd0, arburst}, 32'd0);
        check("rst_i_ret_valid", {31'd0, i_ret_valid}, 32'd0);
        check("rst_d_ret_valid", {31'd0, d_ret_valid}, 32'd0);
        check("rst_perr", {31'd0, protocol_err}, 32'd0);
        check("rst_starve", 32'(dut.r_starve_cnt), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_rready", {31'd0, rready}, 32'd1);

        // ---------------- table: grant / RAW eligibility ----------------
        vecs[0] = '{1'b0, 32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0100, 1'b1, 32'h8000_100C, 1'b1, 32'h8000_1008, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0100, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_1008, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h8000_1000, 1'b0, 32'h0000_0200, 1'b1, 32'h8000_100F, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0100, 1'b1, 32'h8000_100C, 1'b0, 32'h8000_1008, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h0000_0100, 1'b1, 32'h8000_1010, 1'b1, 32'h8000_100F, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 32'h8000_0FFF, 1'b1, 32'h8000_1000, 1'b1, 32'h8000_1000, 1'b1, 1'b0};

        for (int v = 0; v < 10; v++) begin
            tick();
            i_rd_type    = 3'b010;
            d_rd_type    = 3'b010;
            i_rd_req     = vecs[v].i_req;
            i_rd_addr    = vecs[v].i_addr;
            d_rd_req     = vecs[v].d_req;
            d_rd_addr    = vecs[v].d_addr;
            wr_pending   = vecs[v].wr_p;
            wr_pend_addr = vecs[v].wr_a;
            #1;
            check($sformatf("vec%0d_i_rd_rdy", v), {31'd0, i_rd_rdy}, {31'd0, vecs[v].exp_i});
            check($sformatf("vec%0d_d_rd_rdy", v), {31'd0, d_rd_rdy}, {31'd0, vecs[v].exp_d});
            // Withdraw before the edge so nothing is actually accepted.
            i_rd_req   = 1'b0;
            d_rd_req   = 1'b0;
            wr_pending = 1'b0;
        end

        // ---------------- icache line refill ----------------
        tick();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h1C00_0104;
        #1;
        check("line_i_rd_rdy", {31'd0, i_rd_rdy}, 32'd1);
        tick();
        #1;
        check("line_arvalid", {31'd0, arvalid}, 32'd1);
        check("line_arid", {28'd0, arid}, 32'd0);
        check("line_araddr", araddr, 32'h1C00_0100);
        check("line_arlen", {24'd0, arlen}, 32'd3);
        check("line_arsize", {29'd0, arsize}, 32'd2);
        check("line_arburst", {30'd0, arburst}, 32'd1);
        check("line_busy_rdy", {31'd0, i_rd_rdy}, 32'd0);
        ar_accept();
        for (int k = 0; k < 4; k++) begin
            beat(4'd0, 32'hA000_0000 + 32'(k), (k == 3), 1'b1, 1'b0);
            check("line_rdy_during_burst", {31'd0, i_rd_rdy}, 32'd0);
        end
        end_beats();
        check("line_rdy_after_last", {31'd0, i_rd_rdy}, 32'd1);
        i_rd_req = 1'b0;

        // ---------------- simultaneous requests, interleaved returns -----
        tick();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b010;
        i_rd_addr = 32'h0000_0100;
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_0200;
        #1;
        check("tie_d_rdy", {31'd0, d_rd_rdy}, 32'd1);
        check("tie_i_rdy", {31'd0, i_rd_rdy}, 32'd0);
        tick();
        d_rd_req = 1'b0;
        #1;
        check("tie_arid_d", {28'd0, arid}, 32'd1);
        check("tie_araddr_d", araddr, 32'h0000_0200);
        check("tie_arlen_d", {24'd0, arlen}, 32'd0);
        check("tie_i_rdy_arsend", {31'd0, i_rd_rdy}, 32'd0);
        ar_accept();
        check("tie_i_rdy_after_arready", {31'd0, i_rd_rdy}, 32'd1);
        tick();
        i_rd_req = 1'b0;
        #1;
        check("tie_arid_i", {28'd0, arid}, 32'd0);
        check("tie_araddr_i", araddr, 32'h0000_0100);
        ar_accept();
        beat(4'd0, 32'h1111_0000, 1'b0, 1'b1, 1'b0);
        beat(4'd1, 32'h2222_0000, 1'b0, 1'b0, 1'b1);
        beat(4'd0, 32'h1111_0001, 1'b1, 1'b1, 1'b0);
        beat(4'd1, 32'h2222_0001, 1'b1, 1'b0, 1'b1);
        end_beats();
        check("interleave_perr", {31'd0, protocol_err}, 32'd0);

        // ---------------- starvation guard ----------------
        i_rd_addr = 32'h0000_0300;
        d_rd_addr = 32'h0000_0400;
        for (int g = 1; g <= 5; g++) begin
            tick();
            i_rd_req = 1'b1;
            d_rd_req = 1'b1;
            #1;
            check($sformatf("starve_cnt_g%0d", g), 32'(dut.r_starve_cnt), 32'(g - 1));
            check($sformatf("starve_i_rdy_g%0d", g), {31'd0, i_rd_rdy}, (g == 5) ? 32'd1 : 32'd0);
            check($sformatf("starve_d_rdy_g%0d", g), {31'd0, d_rd_rdy}, (g == 5) ? 32'd0 : 32'd1);
            tick();
            i_rd_req = 1'b0;
            d_rd_req = 1'b0;
            #1;
            check($sformatf("starve_arid_g%0d", g), {28'd0, arid}, (g == 5) ? 32'd0 : 32'd1);
            ar_accept();
            if (g == 5) beat(4'd0, 32'h5555_0000, 1'b1, 1'b1, 1'b0);
            else        beat(4'd1, 32'h4444_0000 + 32'(g), 1'b1, 1'b0, 1'b1);
            end_beats();
        end
        check("starve_cnt_cleared", 32'(dut.r_starve_cnt), 32'd0);

        // ---------------- RAW hazard held over several cycles ----------
        wr_pending   = 1'b1;
        wr_pend_addr = 32'h8000_1008;
        d_rd_addr    = 32'h8000_100C;
        for (int c = 0; c < 3; c++) begin
            tick();
            d_rd_req = 1'b1;
            #1;
            check($sformatf("raw_block_c%0d", c), {31'd0, d_rd_rdy}, 32'd0);
        end
        tick();
        wr_pending = 1'b0;
        #1;
        check("raw_release_rdy", {31'd0, d_rd_rdy}, 32'd1);
        tick();
        d_rd_req = 1'b0;
        #1;
        check("raw_araddr", araddr, 32'h8000_100C);
        ar_accept();
        beat(4'd1, 32'h6666_0000, 1'b1, 1'b0, 1'b1);
        end_beats();
        wr_pending = 1'b1;
        d_rd_req   = 1'b1;
        d_rd_addr  = 32'h8000_2000;
        #1;
        check("raw_other_line_rdy", {31'd0, d_rd_rdy}, 32'd1);
        tick();
        d_rd_req   = 1'b0;
        wr_pending = 1'b0;
        #1;
        check("raw_other_araddr", araddr, 32'h8000_2000);
        ar_accept();
        beat(4'd1, 32'h7777_0000, 1'b1, 1'b0, 1'b1);
        end_beats();
        check("raw_perr", {31'd0, protocol_err}, 32'd0);

        // ---------------- stray beats ----------------
        beat(4'd3, 32'hDEAD_0003, 1'b1, 1'b0, 1'b0);
        end_beats();
        check("rid3_perr", {31'd0, protocol_err}, 32'd1);
        tick();
        tick();
        check("rid3_perr_sticky", {31'd0, protocol_err}, 32'd1);
        do_reset();
        beat(4'd1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0);
        end_beats();
        check("rid1_idle_perr", {31'd0, protocol_err}, 32'd1);

        // ---------------- reset mid-burst ----------------
        tick();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h1C00_0200;
        #1;
        check("mid_i_rdy", {31'd0, i_rd_rdy}, 32'd1);
        tick();
        i_rd_req = 1'b0;
        #1;
        ar_accept();
        beat(4'd0, 32'h8888_0000, 1'b0, 1'b1, 1'b0);
        end_beats();
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_0500;
        #1;
        check("mid_d_rdy", {31'd0, d_rd_rdy}, 32'd1);
        tick();
        d_rd_req = 1'b0;
        #1;
        check("mid_arvalid", {31'd0, arvalid}, 32'd1);
        tick();
        reset  = 1'b1;
        rvalid = 1'b1;
        rid    = 4'd0;
        rdata  = 32'h8888_0001;
        rlast  = 1'b0;
        #1;
        check("mid_rst_i_ret_valid", {31'd0, i_ret_valid}, 32'd0);
        check("mid_rst_rready", {31'd0, rready}, 32'd0);
        tick();
        check("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("mid_rst_perr", {31'd0, protocol_err}, 32'd0);
        reset  = 1'b0;
        rvalid = 1'b0;
        #1;
        check("mid_post_perr", {31'd0, protocol_err}, 32'd0);
        i_rd_req  = 1'b1;
        i_rd_type = 3'b010;
        i_rd_addr = 32'h0000_0600;
        #1;
        check("mid_post_i_rdy", {31'd0, i_rd_rdy}, 32'd1);
        i_rd_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
